if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS core. Sits directly upstream of the decoder/control unit.
- Holds the PC and issues word fetches to instruction memory, which has variable response latency.
- Buffers returned instructions in a 2-entry queue and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Accepts redirects (taken beq, j) from downstream and flushes stale fetches.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_queue.sv | 35 +++
 rtl/if_fetch_stage.sv | 66 ++++++
 tb/tb_if_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core widths, instruction field slices and fetch-stage types
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: shift-style instruction FIFO with registered head, same-cycle push/pop and flush
module fetch_queue import mips_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_entry_t mem [DEPTH];
    fetch_entry_t mem_n [DEPTH];
    logic [CW-1:0] wr_idx;
    always_comb begin
        wr_idx = count - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            mem_n[i] = (pop && i < DEPTH - 1) ? mem[(i + 1) % DEPTH] : mem[i];
            if (push && CW'(i) == wr_idx) mem_n[i] = din;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
            count <= flush ? '0 : count - CW'(pop) + CW'(push);
        end
    end
    assign head = mem[0];
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, single-outstanding imem fetch FSM and 2-entry queue toward decode
module if_fetch_stage import mips_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    fetch_state_e state, state_n;
    logic [ADDR_W-1:0] fetch_pc, req_pc;
    logic [CW-1:0] count;
    logic [CW:0] occ;
    logic push, pop, issue;
    fetch_entry_t din, head;
    assign out_valid = count != '0;
    assign pop = out_valid & out_ready;
    always_comb begin
        push = state == WAIT && imem_ack && !redirect_valid;
        occ = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(push);
        // a fetch only leaves when its eventual response is guaranteed a queue slot
        issue = rst_n && !redirect_valid && (state == IDLE || (state == WAIT && imem_ack))
              && occ < (CW+1)'(FIFO_DEPTH);
        state_n = redirect_valid ? ((state == IDLE || imem_ack) ? IDLE : DROP)
                : issue ? WAIT : imem_ack ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= redirect_valid ? (redirect_pc & ~ADDR_W'(3))
                      : issue ? fetch_pc + ADDR_W'(4) : fetch_pc;
            if (issue) req_pc <= fetch_pc;
        end
    end
    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign din = '{instr: imem_rdata, pc: req_pc, pc_plus4: req_pc + ADDR_W'(4)};
    fetch_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc_plus4;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed phases with request/delivery scoreboards fed by a latency-programmable imem model
module tb_if_fetch_stage;
    logic clk = 0, rst_n = 0;
    logic imem_req, imem_ack = 0, out_valid, out_ready = 0, redirect_valid = 0;
    logic [31:0] imem_addr, imem_rdata = 0, out_instr, out_pc, out_pc_plus4, redirect_pc = 0;
    int n_checks = 0, n_fail = 0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_del[$];
    typedef struct { int due; logic [31:0] data; } mem_rsp_t;
    mem_rsp_t pend[$];
    int cyc = 0, lat = 1;
    logic hold = 0;
    logic [31:0] salt = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // imem model: responses keep the data computed at request time, so a salted stale reply is recognisable
    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (!rst_n && !hold) pend.delete();
        imem_ack = 0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            imem_ack = 1;
            imem_rdata = pend[0].data;
            void'(pend.pop_front());
        end
        #1;
        if (imem_req === 1'b1) begin
            pend.push_back('{due: cyc + lat, data: ~imem_addr ^ salt});
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got %h, expected no request", imem_addr);
            end else check("req_addr", imem_addr, exp_req.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_del.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_delivery: got pc %h, expected none", out_pc);
            end else begin
                logic [31:0] p;
                p = exp_del.pop_front();
                check("out_pc", out_pc, p);
                check("out_instr", out_instr, ~p);
                check("out_pc_plus4", out_pc_plus4, p + 32'd4);
            end
        end
    end

    task automatic do_reset(input string phase);
        @(negedge clk);
        rst_n = 0;
        redirect_valid = 0;
        out_ready = 0;
        #3;
        check({phase, "_reqs_left"}, 32'(exp_req.size()), 0);
        check({phase, "_dels_left"}, 32'(exp_del.size()), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_pc_plus4", out_pc_plus4, 0);
        exp_req.delete();
        exp_del.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        do_reset("init");
        lat = 1; out_ready = 1;
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        exp_del = '{32'h0, 32'h4, 32'h8, 32'hC};
        step(5);
        do_reset("stream");

        out_ready = 0;
        exp_req = '{32'h0, 32'h4};
        step(5);
        #3 check("stall_req", 32'(imem_req), 0);
        step(4);
        #3;
        check("stall_valid", 32'(out_valid), 1);
        check("stall_head_pc", out_pc, 32'h0);
        check("stall_head_instr", out_instr, 32'hFFFF_FFFF);
        check("stall_req_late", 32'(imem_req), 0);
        step(1);
        out_ready = 1;
        exp_req.push_back(32'h8); exp_req.push_back(32'hC); exp_req.push_back(32'h10);
        exp_del = '{32'h0, 32'h4, 32'h8};
        step(2);
        do_reset("backpressure");

        lat = 3; out_ready = 1;
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_del = '{32'h0, 32'h4};
        step(7);
        redirect_valid = 1; redirect_pc = 32'h0000_0103;
        exp_req.push_back(32'h100); exp_req.push_back(32'h104);
        exp_del.push_back(32'h100);
        step(1);
        redirect_valid = 0;
        #3 check("redir_flushed", 32'(out_valid), 0);
        step(1);
        #3;
        check("drop_no_issue", 32'(imem_req), 0);
        check("drop_valid", 32'(out_valid), 0);
        step(5);
        do_reset("redirect");

        lat = 1; out_ready = 1;
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_del = '{32'h0, 32'h4};
        step(3);
        redirect_valid = 1; redirect_pc = 32'h0000_0200;
        exp_req.push_back(32'h200); exp_req.push_back(32'h204); exp_req.push_back(32'h208);
        exp_del.push_back(32'h200);
        #3 check("redir_ack_no_issue", 32'(imem_req), 0);
        step(1);
        redirect_valid = 0;
        #3;
        check("redir_ack_empty", 32'(out_valid), 0);
        check("redir_ack_issue", 32'(imem_req), 1);
        check("redir_ack_addr", imem_addr, 32'h200);
        step(2);
        do_reset("redirect_ack");

        lat = 2; salt = 32'hDEAD_0000; out_ready = 1;
        exp_req = '{32'h0, 32'h0, 32'h4};
        exp_del = '{32'h0};
        step(1);
        rst_n = 0; hold = 1;
        #3;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_req", 32'(imem_req), 0);
        step(1);
        rst_n = 1; salt = 0;
        #3;
        check("release_valid", 32'(out_valid), 0);
        check("release_req", 32'(imem_req), 1);
        check("release_addr", imem_addr, 32'h0);
        step(1);
        hold = 0;
        #3 check("release_valid_c3", 32'(out_valid), 0);
        step(1);
        #3 check("release_valid_c4", 32'(out_valid), 0);
        step(1);
        do_reset("reset_midop");

        lat = 1; out_ready = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
        exp_req = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_del = '{32'hFFFF_FFFC, 32'h0};
        #3 check("wrap_redir_no_issue", 32'(imem_req), 0);
        step(1);
        redirect_valid = 0;
        step(3);
        do_reset("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
